// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART frame controller
//
// Purpose: FSM state encoding, default framing bytes and baud codes used by
// uart_rx_frame_ctrl and its frame buffer.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic [7:0] HDR_DEFAULT        = 8'h55;
  localparam logic [7:0] CFG_OPCODE_DEFAULT = 8'hB0;

  localparam logic [2:0] BAUD_115200 = 3'd0;
  localparam logic [2:0] BAUD_9600_A = 3'd1;
  localparam logic [2:0] BAUD_9600_B = 3'd2;

  // Highest baud code the receiver understands; anything above is rejected.
  localparam logic [2:0] BAUD_CODE_MAX = BAUD_9600_B;

  // Running 8-bit checksum step; a frame is good when the final residue is 0.
  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload buffer, one sync write port, one registered read port
//
// Purpose: holds the payload of the frame being received / held for the host.
// Ports:
//   sysclk, rst        clock, asynchronous active-low reset (read register only)
//   wr_en/addr/data    synchronous write port
//   rd_addr            read index; indexes at or beyond DEPTH read as 0
//   rd_data            registered read data, one cycle after rd_addr
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [7:0] mem [DEPTH];
  logic       wr_in_range;
  logic       rd_in_range;

  // Extra MSB keeps the compare meaningful when DEPTH is a power of two.
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  always_ff @(posedge sysclk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      rd_data <= 8'd0;
    end else if (rd_in_range) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= 8'd0;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - sequences UART bytes into checked command frames
//
// Purpose: parses HDR, LEN, payload, CHK from the receiver byte stream, holds
// one good frame for the host, and consumes baud-config frames internally.
// Ports:
//   sysclk, rst            clock, asynchronous active-low reset
//   rx_data, rx_done       receiver byte and its one-cycle strobe
//   baud_set               receiver baud code
//   frame_valid/ready      host handshake for the held frame
//   frame_len              payload length of the held frame
//   rd_addr, rd_data       payload read port, one cycle latency
//   err_len/chk/timeout/ovf/cfg   one-cycle error pulses
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] HDR          = HDR_DEFAULT,
  parameter logic [7:0] CFG_OPCODE   = CFG_OPCODE_DEFAULT,
  parameter int         TIMEOUT_CLKS = 20000,
  localparam int        AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  output logic [2:0]    baud_set,
  output logic          frame_valid,
  input  logic          frame_ready,
  output logic [7:0]    frame_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          err_len,
  output logic          err_chk,
  output logic          err_timeout,
  output logic          err_ovf,
  output logic          err_cfg
);

  localparam int            TW        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  state_t        state_q, state_d;
  logic [7:0]    len_q, sum_q, idx_q;
  logic [7:0]    b0_q, b1_q;
  logic [TW-1:0] tmo_cnt;

  logic counting, tmo_hit;
  logic len_ld, pay_wr, cfg_ld, frame_ld, frame_clr;
  logic err_len_d, err_chk_d, err_tmo_d, err_ovf_d, err_cfg_d;

  assign counting = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK);
  assign tmo_hit  = counting && !rx_done && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    len_ld    = 1'b0;
    pay_wr    = 1'b0;
    cfg_ld    = 1'b0;
    frame_ld  = 1'b0;
    frame_clr = 1'b0;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovf_d = 1'b0;
    err_cfg_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_done && rx_data == HDR) state_d = LEN;
      end
      LEN: begin
        if (rx_done) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = IDLE;
          end else begin
            len_ld  = 1'b1;
            state_d = PAYLOAD;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end
      end
      PAYLOAD: begin
        if (rx_done) begin
          pay_wr = 1'b1;
          if (idx_q == len_q - 8'd1) state_d = CHK;
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end
      end
      CHK: begin
        if (rx_done) begin
          state_d = IDLE;
          if (sum8(sum_q, rx_data) != 8'd0) begin
            err_chk_d = 1'b1;
          end else if (len_q == 8'd2 && b0_q == CFG_OPCODE) begin
            // Config frames never reach the host.
            if (b1_q <= {5'd0, BAUD_CODE_MAX}) cfg_ld = 1'b1;
            else err_cfg_d = 1'b1;
          end else begin
            frame_ld = 1'b1;
            state_d  = HOLD;
          end
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          // A byte landing on the handshake cycle is treated as seen in IDLE.
          frame_clr = 1'b1;
          state_d   = (rx_done && rx_data == HDR) ? LEN : IDLE;
        end else if (rx_done) begin
          err_ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (rx_done || !counting) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      b0_q        <= 8'd0;
      b1_q        <= 8'd0;
      baud_set    <= BAUD_115200;
      frame_valid <= 1'b0;
      frame_len   <= 8'd0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
      err_cfg     <= 1'b0;
    end else begin
      err_len     <= err_len_d;
      err_chk     <= err_chk_d;
      err_timeout <= err_tmo_d;
      err_ovf     <= err_ovf_d;
      err_cfg     <= err_cfg_d;
      if (len_ld) begin
        len_q <= rx_data;
        sum_q <= rx_data;
        idx_q <= 8'd0;
      end
      if (pay_wr) begin
        sum_q <= sum8(sum_q, rx_data);
        idx_q <= idx_q + 8'd1;
        // First two payload bytes are shadowed for config-frame decoding.
        if (idx_q == 8'd0) b0_q <= rx_data;
        if (idx_q == 8'd1) b1_q <= rx_data;
      end
      if (cfg_ld) baud_set <= b1_q[2:0];
      if (frame_ld) begin
        frame_valid <= 1'b1;
        frame_len   <= len_q;
      end
      if (frame_clr) frame_valid <= 1'b0;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .sysclk  (sysclk),
    .rst     (rst),
    .wr_en   (pay_wr),
    .wr_addr (idx_q[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - randomized self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int T       = 64;
  localparam int AW      = $clog2(MAX_LEN);

  localparam int O_FRAME  = 0;
  localparam int O_LEN    = 1;
  localparam int O_CHK    = 2;
  localparam int O_CFG    = 3;
  localparam int O_CFGERR = 4;
  localparam int O_TO     = 5;

  logic          sysclk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_done = 1'b0;
  logic [2:0]    baud_set;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [7:0]    frame_len;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          err_len, err_chk, err_timeout, err_ovf, err_cfg;

  always #5 sysclk = ~sysclk;

  uart_rx_frame_ctrl #(
    .MAX_LEN      (MAX_LEN),
    .HDR          (8'h55),
    .CFG_OPCODE   (8'hB0),
    .TIMEOUT_CLKS (T)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .baud_set    (baud_set),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .err_len     (err_len),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .err_ovf     (err_ovf),
    .err_cfg     (err_cfg)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Error pulse counters, sampled mid-cycle.
  int c_len = 0, c_chk = 0, c_to = 0, c_ovf = 0, c_cfg = 0;
  int s_len, s_chk, s_to, s_ovf, s_cfg;

  always @(negedge sysclk) begin
    if (err_len)     c_len <= c_len + 1;
    if (err_chk)     c_chk <= c_chk + 1;
    if (err_timeout) c_to  <= c_to + 1;
    if (err_ovf)     c_ovf <= c_ovf + 1;
    if (err_cfg)     c_cfg <= c_cfg + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model state
  logic [7:0] pay [0:255];
  logic [2:0] exp_baud = 3'd0;
  logic [7:0] txq [$];

  function automatic logic [7:0] frame_chk(input logic [7:0] len);
    logic [7:0] s = len;
    for (int i = 0; i < int'(len); i++) s = s + pay[i];
    return 8'd0 - s;
  endfunction

  // Outcome of HDR followed by nsent further bytes of (len, payload, chk).
  function automatic int outcome(input logic [7:0] len, input logic [7:0] chk, input int nsent);
    int s;
    if (nsent == 0) return O_TO;
    if (len == 8'd0 || int'(len) > MAX_LEN) return O_LEN;
    if (nsent < int'(len) + 2) return O_TO;
    s = int'(len) + int'(chk);
    for (int i = 0; i < int'(len); i++) s += int'(pay[i]);
    if (s % 256 != 0) return O_CHK;
    if (len == 8'd2 && pay[0] == 8'hB0) return (pay[1] <= 8'd2) ? O_CFG : O_CFGERR;
    return O_FRAME;
  endfunction

  function automatic int gap_pick();
    if ($urandom_range(0, 7) == 0) return T - 2;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sysclk);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge sysclk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic send_txq(input bit rand_gaps);
    for (int i = 0; i < txq.size(); i++) begin
      send_byte(txq[i]);
      if (rand_gaps && i != txq.size() - 1) idle(gap_pick());
    end
  endtask

  task automatic build(input logic [7:0] len, input logic [7:0] chk, input int nsent);
    txq.delete();
    txq.push_back(8'h55);
    if (nsent >= 1) txq.push_back(len);
    for (int i = 0; i < int'(len); i++) if (i + 2 <= nsent) txq.push_back(pay[i]);
    if (nsent >= int'(len) + 2) txq.push_back(chk);
  endtask

  task automatic snap();
    s_len = c_len; s_chk = c_chk; s_to = c_to; s_ovf = c_ovf; s_cfg = c_cfg;
  endtask

  task automatic check_errs(input string tag, input int e_len, input int e_chk,
                            input int e_to, input int e_ovf, input int e_cfg);
    check({tag, ".err_len"},     32'(c_len - s_len), 32'(e_len));
    check({tag, ".err_chk"},     32'(c_chk - s_chk), 32'(e_chk));
    check({tag, ".err_timeout"}, 32'(c_to - s_to),   32'(e_to));
    check({tag, ".err_ovf"},     32'(c_ovf - s_ovf), 32'(e_ovf));
    check({tag, ".err_cfg"},     32'(c_cfg - s_cfg), 32'(e_cfg));
  endtask

  task automatic read_back(input string tag, input logic [7:0] len);
    for (int i = 0; i < int'(len); i++) begin
      @(negedge sysclk);
      rd_addr = AW'(i);
      @(posedge sysclk);
      #1;
      check({tag, ".rd_data"}, 32'(rd_data), 32'(pay[i]));
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge sysclk);
    frame_ready = 1'b1;
    @(posedge sysclk);
    #1;
    frame_ready = 1'b0;
    check({tag, ".valid_after_hs"}, 32'(frame_valid), 32'd0);
  endtask

  task automatic run_item(input string tag, input logic [7:0] len, input logic [7:0] chk,
                          input int nsent, input bit try_ovf);
    int o;
    o = outcome(len, chk, nsent);
    snap();
    build(len, chk, nsent);
    send_txq(1'b1);
    idle((o == O_TO) ? T + 2 : 2);
    if (o == O_CFG) exp_baud = pay[1][2:0];
    check_errs(tag, int'(o == O_LEN), int'(o == O_CHK), int'(o == O_TO), 0, int'(o == O_CFGERR));
    check({tag, ".frame_valid"}, 32'(frame_valid), 32'(o == O_FRAME));
    check({tag, ".baud_set"}, 32'(baud_set), 32'(exp_baud));
    if (o == O_FRAME) begin
      check({tag, ".frame_len"}, 32'(frame_len), 32'(len));
      if (try_ovf) begin
        snap();
        send_byte(8'($urandom_range(0, 255)));
        idle(1);
        check_errs({tag, ".ovf"}, 0, 0, 0, 1, 0);
        check({tag, ".valid_kept"}, 32'(frame_valid), 32'd1);
      end
      read_back(tag, len);
      handshake(tag);
    end
  endtask

  initial begin
    logic [7:0] len, chk, b;
    int kind, nsent;

    // Reset state
    idle(3);
    check("rst.baud_set", 32'(baud_set), 32'd0);
    check("rst.frame_valid", 32'(frame_valid), 32'd0);
    check("rst.frame_len", 32'(frame_len), 32'd0);
    check("rst.rd_data", 32'(rd_data), 32'd0);
    check("rst.errs", 32'({err_len, err_chk, err_timeout, err_ovf, err_cfg}), 32'd0);
    @(negedge sysclk);
    rst = 1'b1;
    idle(2);

    // 1: basic frame
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    run_item("t1", 8'd3, 8'h97, 5, 1'b0);

    // 2: bad checksum, with exact pulse timing
    pay[0] = 8'hAA;
    snap();
    build(8'd1, 8'h00, 3);
    send_txq(1'b0);
    check("t2.chk_pulse", 32'(err_chk), 32'd1);
    idle(1);
    check("t2.chk_pulse_end", 32'(err_chk), 32'd0);
    idle(1);
    check_errs("t2", 0, 1, 0, 0, 0);
    check("t2.frame_valid", 32'(frame_valid), 32'd0);
    run_item("t2b", 8'd1, frame_chk(8'd1), 3, 1'b0);

    // 3: config frames
    pay[0] = 8'hB0; pay[1] = 8'h01;
    run_item("t3a", 8'd2, 8'h4D, 4, 1'b0);
    pay[1] = 8'h05;
    run_item("t3b", 8'd2, 8'h49, 4, 1'b0);

    // 4: timeout, exact expiry cycle
    pay[0] = 8'hAA;
    snap();
    build(8'd2, 8'h00, 2);
    send_txq(1'b0);
    idle(T - 1);
    check("t4.not_yet", 32'(err_timeout), 32'd0);
    idle(1);
    check("t4.expired", 32'(err_timeout), 32'd1);
    idle(2);
    check_errs("t4", 0, 0, 1, 0, 0);
    pay[0] = 8'h01; pay[1] = 8'h02;
    run_item("t4b", 8'd2, frame_chk(8'd2), 4, 1'b0);

    // 5: overflow while held, then handshake with simultaneous header
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    build(8'd3, 8'h97, 5);
    send_txq(1'b0);
    idle(1);
    @(negedge sysclk);
    rd_addr = AW'(1);
    idle(1);
    snap();
    send_byte(8'h55);
    idle(1);
    check_errs("t5.ovf", 0, 0, 0, 1, 0);
    check("t5.rd_stable", 32'(rd_data), 32'h22);
    check("t5.valid_kept", 32'(frame_valid), 32'd1);
    @(negedge sysclk);
    frame_ready = 1'b1;
    rx_data = 8'h55;
    rx_done = 1'b1;
    @(posedge sysclk);
    #1;
    frame_ready = 1'b0;
    rx_done = 1'b0;
    check("t5.valid_after_hs", 32'(frame_valid), 32'd0);
    snap();
    txq.delete();
    txq.push_back(8'd3); txq.push_back(8'h11); txq.push_back(8'h22);
    txq.push_back(8'h33); txq.push_back(8'h97);
    send_txq(1'b0);
    idle(2);
    check_errs("t5.resume", 0, 0, 0, 0, 0);
    check("t5.resume_valid", 32'(frame_valid), 32'd1);
    read_back("t5", 8'd3);
    handshake("t5");

    // 6: bad lengths, then reset mid-payload after baud_set=2
    run_item("t6a", 8'd0, 8'd0, 1, 1'b0);
    run_item("t6b", 8'h11, 8'd0, 1, 1'b0);
    pay[0] = 8'hB0; pay[1] = 8'h02;
    run_item("t6c", 8'd2, frame_chk(8'd2), 4, 1'b0);
    txq.delete();
    txq.push_back(8'h55); txq.push_back(8'd5); txq.push_back(8'h01); txq.push_back(8'h02);
    send_txq(1'b0);
    @(negedge sysclk);
    rst = 1'b0;
    #1;
    check("t6.rst_baud", 32'(baud_set), 32'd0);
    check("t6.rst_valid", 32'(frame_valid), 32'd0);
    check("t6.rst_len", 32'(frame_len), 32'd0);
    check("t6.rst_rd", 32'(rd_data), 32'd0);
    check("t6.rst_errs", 32'({err_len, err_chk, err_timeout, err_ovf, err_cfg}), 32'd0);
    @(negedge sysclk);
    rst = 1'b1;
    exp_baud = 3'd0;
    snap();
    txq.delete();
    txq.push_back(8'h03); txq.push_back(8'h04); txq.push_back(8'h05);
    send_txq(1'b0);
    idle(T + 2);
    check_errs("t6.after_rst", 0, 0, 0, 0, 0);
    check("t6.after_rst_valid", 32'(frame_valid), 32'd0);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      kind = int'($urandom_range(0, 6));
      len = 8'($urandom_range(1, MAX_LEN));
      for (int i = 0; i < 256; i++) pay[i] = 8'($urandom_range(0, 255));
      nsent = int'(len) + 2;
      chk = frame_chk(len);
      case (kind)
        2: chk = chk + 8'($urandom_range(1, 255));
        3: begin
          len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
          nsent = 1;
        end
        4: begin
          len = 8'd2;
          pay[0] = 8'hB0;
          pay[1] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(3, 255))
                                               : 8'($urandom_range(0, 2));
          chk = frame_chk(len);
          nsent = 4;
        end
        5: nsent = int'($urandom_range(0, int'(len) + 1));
        default: ;
      endcase
      if (kind == 6) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h55) b = 8'h54;
        snap();
        send_byte(b);
        idle(2);
        check_errs("rnd.junk", 0, 0, 0, 0, 0);
        check("rnd.junk_valid", 32'(frame_valid), 32'd0);
      end else begin
        run_item("rnd", len, chk, nsent, 1'($urandom_range(0, 1)));
      end
      idle(int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
